// File: rtl/stego_embed_ctrl.sv
// stego_embed_ctrl: sequencing controller for the encrypt-and-embed datapath.
// Streams cover bytes in and stego bytes out under valid/ready handshakes.
// Each of the first NUM_TEXT bytes gets bit 0 of (text nibble ^ key nibble) in
// its LSB; the key index wraps modulo NUM_KEY. Later bytes pass through unchanged.
//
// Handshake contract (both streams): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its data stable
// until the transfer. The output stage is a single register: it can take a new
// byte in the same cycle the held byte drains.
module stego_embed_ctrl #(
  parameter int NUM_PIXELS = 3072,
  parameter int NUM_TEXT   = 344,
  parameter int NUM_KEY    = 208,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             truncated,
  input  logic [7:0]       pix_in_data,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [7:0]       pix_out_data,
  output logic             pix_out_valid,
  input  logic             pix_out_ready,
  output logic [CNT_W-1:0] txt_addr,
  input  logic [3:0]       txt_data,
  output logic [CNT_W-1:0] key_addr,
  input  logic [3:0]       key_data,
  output logic [CNT_W:0]   embed_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAST_KEY = CNT_W'(NUM_KEY - 1);
  localparam logic [CNT_W:0]   TEXT_LIM = (CNT_W+1)'(NUM_TEXT);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   EMB_ONE  = (CNT_W+1)'(1);
  localparam logic             TRUNC    = (NUM_TEXT > NUM_PIXELS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pix_idx_q, pix_idx_d;
  logic [CNT_W-1:0] txt_addr_q, txt_addr_d;
  logic [CNT_W-1:0] key_addr_q, key_addr_d;
  logic [CNT_W:0]   embed_cnt_q, embed_cnt_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             trunc_q, trunc_d;
  logic             in_ready;
  logic             accept;

  // State and datapath registers; reset returns everything to idle zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pix_idx_q   <= '0;
      txt_addr_q  <= '0;
      key_addr_q  <= '0;
      embed_cnt_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_idx_q   <= pix_idx_d;
      txt_addr_q  <= txt_addr_d;
      key_addr_q  <= key_addr_d;
      embed_cnt_q <= embed_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      trunc_q     <= trunc_d;
    end
  end

  // Next-state, embed datapath and handshake logic.
  always_comb begin
    state_d     = state_q;
    pix_idx_d   = pix_idx_q;
    txt_addr_d  = txt_addr_q;
    key_addr_d  = key_addr_q;
    embed_cnt_d = embed_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    trunc_d     = trunc_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle is also IDLE; a start there is deliberately dropped.
        if (start && !done_q) begin
          pix_idx_d   = '0;
          txt_addr_d  = '0;
          key_addr_d  = '0;
          embed_cnt_d = '0;
          trunc_d     = TRUNC;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = !out_valid_q || pix_out_ready;
        accept   = pix_in_valid && in_ready;
        if (accept) begin
          if ({1'b0, pix_idx_q} < TEXT_LIM) begin
            // Only bit 0 of the XOR nibble is embedded.
            out_data_d  = {pix_in_data[7:1], txt_data[0] ^ key_data[0]};
            embed_cnt_d = embed_cnt_q + EMB_ONE;
            txt_addr_d  = txt_addr_q + IDX_ONE;
            key_addr_d  = (key_addr_q == LAST_KEY) ? '0 : key_addr_q + IDX_ONE;
          end else begin
            out_data_d = pix_in_data;
          end
          out_valid_d = 1'b1;
          pix_idx_d   = pix_idx_q + IDX_ONE;
          if (pix_idx_q == LAST_PIX) state_d = S_FLUSH;
        end else if (pix_out_ready && out_valid_q) begin
          out_valid_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (out_valid_q && pix_out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign truncated     = trunc_q;
  assign pix_in_ready  = in_ready;
  assign pix_out_data  = out_data_q;
  assign pix_out_valid = out_valid_q;
  assign txt_addr      = txt_addr_q;
  assign key_addr      = key_addr_q;
  assign embed_count   = embed_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/stego_embed_ctrl.md
Name: stego_embed_ctrl

Overview:
- Sequencing controller for the encrypt-and-embed datapath.
- Streams cover-image bytes in and stego bytes out under valid/ready handshakes.
- Reads text and key nibbles from asynchronous-read memories and XORs each text nibble with the key nibble; the key wraps cyclically.
- Writes bit 0 of the XOR result into the pixel LSB. Pixels beyond the message pass through unchanged.
- Sits between the image reader and the image writer in place of free-running enable strobes.

Parameters:
- NUM_PIXELS, 3072, bytes per image (32*32*3).
- NUM_TEXT, 344, text nibbles to embed.
- NUM_KEY, 208, key nibbles; key index wraps modulo NUM_KEY.
- CNT_W, 12, counter/address width; must hold NUM_PIXELS-1, NUM_TEXT-1 and NUM_KEY-1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to process one image; honoured only in IDLE
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse when the last output byte has been accepted
- truncated  out  1  sticky; set when NUM_TEXT > NUM_PIXELS; cleared on start/reset
- pix_in_data  in  8  cover byte
- pix_in_valid  in  1  cover byte valid
- pix_in_ready  out  1  controller accepts cover byte
- pix_out_data  out  8  stego byte (registered)
- pix_out_valid  out  1  stego byte valid
- pix_out_ready  in  1  downstream accepts stego byte
- txt_addr  out  CNT_W  text memory index (registered)
- txt_data  in  4  text nibble at txt_addr, same-cycle (asynchronous read)
- key_addr  out  CNT_W  key memory index (registered)
- key_data  in  4  key nibble at key_addr, same-cycle
- embed_count  out  CNT_W+1  number of bytes that received a message bit this run

Behaviour:
- Reset (sync, active-high) sets every register at the next edge, regardless of state:
  - state = IDLE; all counters = 0.
  - busy, done, pix_out_valid, truncated = 0.
  - pix_out_data = 0, txt_addr = 0, key_addr = 0, embed_count = 0.
- Reset mid-run abandons the image. No done pulse is produced and any pending output byte is dropped.
- FSM states:
  - IDLE: pix_in_ready = 0. On start: pix_idx, txt_addr, key_addr and embed_count are set to 0, truncated = (NUM_TEXT > NUM_PIXELS), go to RUN.
  - RUN: pix_in_ready = !pix_out_valid || pix_out_ready. A byte is accepted on a cycle where pix_in_valid && pix_in_ready.
  - On accept, if pix_idx < NUM_TEXT: pix_out_data <= {pix_in_data[7:1], txt_data[0]^key_data[0]}; embed_count++; txt_addr++; key_addr <= (key_addr == NUM_KEY-1) ? 0 : key_addr+1.
  - On accept, otherwise: pix_out_data <= pix_in_data; txt_addr and key_addr hold.
  - On every accept: pix_out_valid <= 1; pix_idx++. If pix_idx == NUM_PIXELS-1, go to FLUSH.
  - If pix_out_ready && pix_out_valid and there is no accept, pix_out_valid <= 0.
  - FLUSH: pix_in_ready = 0. Wait until pix_out_valid && pix_out_ready. Then clear pix_out_valid, assert done for one cycle and go to IDLE.
- Latency: one cycle from input accept to pix_out_valid. Full throughput (one byte per cycle) when pix_out_ready is held high.
- Backpressure:
  - pix_out_data and pix_out_valid hold stable while pix_out_valid && !pix_out_ready.
  - An input byte may be accepted in the same cycle the held byte drains.
- The upper three bits of the XOR nibble are discarded. Only bit 0 is embedded.
- start while busy or in the done cycle is ignored.
- A start in the cycle after done is honoured.
- pix_in_valid outside RUN is ignored; no byte is consumed.

Test Plan:
Bench parameters for the first three lines: NUM_PIXELS=8, NUM_TEXT=5, NUM_KEY=3.
- Basic embed with ready held high:
  - Stimulus: pixels 0xFF,0x00,0xAA,0x55,0x10,0x11,0x12,0x13; txt = 1,0,1,1,0; key = 1,1,0 (wraps).
  - Required: outputs 0xFE,0x01,0xAB,0x54,0x11,0x11,0x12,0x13; embed_count = 5; done exactly one cycle after the 8th output handshake; busy low afterwards.
- Key wrap: key_addr sequence on successive accepts is 0,1,2,0,1; txt_addr stops at 5 and holds through pass-through bytes.
- Backpressure: drop pix_out_ready for 3 cycles mid-stream.
  - Required: pix_in_ready = 0 during the stall; pix_out_data stable.
  - No byte is lost or duplicated; output matches the unstalled run.
- Truncation: with NUM_TEXT=10 and NUM_PIXELS=8:
  - truncated = 1 from start; embed_count = 8.
  - All 8 bytes carry message bits; done still pulses.
- Reset mid-run: assert reset after 3 accepts.
  - Required: next cycle state IDLE, pix_out_valid = 0, txt_addr = key_addr = 0, no done.
  - A new start then reproduces the basic-embed outputs exactly.
- start ignored while busy: a pulse during RUN changes no counter. A second start in the cycle after done launches a fresh run from index 0.
